// File: rtl/dekatron_seek.sv
// dekatron_seek: steps an emulated 10-position one-hot glow ring from its
// current digit to a requested BCD digit along the shorter direction, one
// step every STEP_DIV clocks. It emits a one-cycle pulse per step and
// reports the ring position both one-hot and as BCD.
module dekatron_seek #(
    parameter int STEP_DIV = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Request,
    input  logic [3:0] Target,
    output logic       Busy,
    output logic       Ready,
    output logic       Error,
    output logic       PulseUp,
    output logic       PulseDown,
    output logic [9:0] Position,
    output logic [3:0] Digit
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEEK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       pos_q, pos_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tgt_q, tgt_d;
    logic             dir_up_q, dir_up_d;
    logic             err_q, err_d;
    logic             pulse_up_q, pulse_up_d;
    logic             pulse_dn_q, pulse_dn_d;

    logic [4:0]       diff;
    logic [3:0]       dist_up;

    // One-hot ring position to BCD digit; the ring is always one-hot.
    function automatic logic [3:0] ring_to_bcd(input logic [9:0] ring);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (ring[i]) d = 4'(i);
        end
        return d;
    endfunction

    // Rotate the ring one place; bit 9 wraps to 0 going up, 0 to 9 going down.
    function automatic logic [9:0] ring_rotate(input logic [9:0] ring, input logic up);
        return up ? {ring[8:0], ring[9]} : {ring[0], ring[9:1]};
    endfunction

    assign Digit     = ring_to_bcd(pos_q);
    assign Position  = pos_q;
    assign Busy      = (state_q == S_SEEK);
    assign Ready     = (state_q == S_DONE);
    assign Error     = err_q;
    assign PulseUp   = pulse_up_q;
    assign PulseDown = pulse_dn_q;

    // Upward distance (Target - current) mod 10; only meaningful for Target <= 9.
    always_comb begin
        diff = {1'b0, Target} + 5'd10 - {1'b0, Digit};
        if (diff >= 5'd10) diff = diff - 5'd10;
        dist_up = diff[3:0];
    end

    // Next-state logic: accept requests in IDLE, step the ring in SEEK, strobe in DONE.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        div_d      = div_q;
        tgt_d      = tgt_q;
        dir_up_d   = dir_up_q;
        err_d      = 1'b0;
        pulse_up_d = 1'b0;
        pulse_dn_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Request) begin
                    if (Target > 4'd9) begin
                        err_d = 1'b1;
                    end else begin
                        tgt_d = Target;
                        div_d = '0;
                        if (dist_up == 4'd0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d  = S_SEEK;
                            // A distance of exactly 5 either way resolves upward.
                            dir_up_d = (dist_up <= 4'd5);
                        end
                    end
                end
            end
            S_SEEK: begin
                if (div_q == DIV_LAST) begin
                    div_d      = '0;
                    pos_d      = ring_rotate(pos_q, dir_up_q);
                    pulse_up_d = dir_up_q;
                    pulse_dn_d = !dir_up_q;
                    if (pos_d == (10'd1 << tgt_q)) state_d = S_DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset parks the ring on digit 0.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            pos_q      <= 10'b0000000001;
            div_q      <= '0;
            tgt_q      <= 4'd0;
            dir_up_q   <= 1'b0;
            err_q      <= 1'b0;
            pulse_up_q <= 1'b0;
            pulse_dn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            div_q      <= div_d;
            tgt_q      <= tgt_d;
            dir_up_q   <= dir_up_d;
            err_q      <= err_d;
            pulse_up_q <= pulse_up_d;
            pulse_dn_q <= pulse_dn_d;
        end
    end

endmodule

// File: tb/tb_dekatron_seek.sv
// Bench for dekatron_seek: directed seeks on a STEP_DIV=4 instance checked
// every cycle against an arithmetic timeline model, plus literal expectations,
// and a STEP_DIV=1 instance checked cycle by cycle by hand.
module tb_dekatron_seek;

    localparam int SD = 4;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Request = 1'b0;
    logic [3:0] Target = 4'd0;
    logic       Busy, Ready, Error, PulseUp, PulseDown;
    logic [9:0] Position;
    logic [3:0] Digit;

    logic       Request1 = 1'b0;
    logic [3:0] Target1 = 4'd0;
    logic       Busy1, Ready1, Error1, PulseUp1, PulseDown1;
    logic [9:0] Position1;
    logic [3:0] Digit1;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    logic [9:0] pos_log [10];
    int npos = 0;

    dekatron_seek #(.STEP_DIV(SD)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Request(Request), .Target(Target),
        .Busy(Busy), .Ready(Ready), .Error(Error), .PulseUp(PulseUp),
        .PulseDown(PulseDown), .Position(Position), .Digit(Digit)
    );

    dekatron_seek #(.STEP_DIV(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Request(Request1), .Target(Target1),
        .Busy(Busy1), .Ready(Ready1), .Error(Error1), .PulseUp(PulseUp1),
        .PulseDown(PulseDown1), .Position(Position1), .Digit(Digit1)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Timeline model: a seek accepted at edge e0 from digit base with
    // distance d has taken min(d, r/SD) steps r edges later.
    int m_n = 0, m_e0 = 0, m_d = 0, m_base = 0, m_err_n = -1;
    bit m_have = 1'b0, m_up = 1'b0;

    function automatic int mpos(input int n);
        int s;
        if (!m_have) return m_base;
        s = (n - m_e0) / SD;
        if (s > m_d) s = m_d;
        return m_up ? (m_base + s) % 10 : (m_base + 10 - s) % 10;
    endfunction

    always @(posedge Clk or negedge Rst_n) begin : model
        int cur, du;
        bit idle;
        if (!Rst_n) begin
            m_n = 0; m_have = 1'b0; m_base = 0; m_err_n = -1;
        end else begin
            cur = mpos(m_n);
            m_n++;
            idle = !m_have || ((m_n - m_e0) >= m_d * SD + 2);
            if (idle && Request) begin
                if (int'(Target) > 9) begin
                    m_err_n = m_n;
                end else begin
                    du = (int'(Target) + 10 - cur) % 10;
                    m_base = cur;
                    m_e0 = m_n;
                    m_have = 1'b1;
                    m_up = (du <= 5);
                    m_d = (du <= 5) ? du : 10 - du;
                end
            end
        end
    end

    always @(negedge Clk) begin : compare
        int ep, r;
        bit eb, er, ep_pulse;
        if (cmp_en) begin
            ep = mpos(m_n);
            eb = 1'b0; er = 1'b0; ep_pulse = 1'b0;
            if (m_have) begin
                r = m_n - m_e0;
                eb = (r < m_d * SD);
                er = (r == m_d * SD);
                ep_pulse = (m_d > 0) && (r >= SD) && (r % SD == 0) && (r / SD <= m_d);
            end
            chk("cyc_position", int'(Position), 1 << ep);
            chk("cyc_digit", int'(Digit), ep);
            chk("cyc_busy", int'(Busy), int'(eb));
            chk("cyc_ready", int'(Ready), int'(er));
            chk("cyc_error", int'(Error), int'(m_n == m_err_n));
            chk("cyc_pulse_up", int'(PulseUp), int'(ep_pulse && m_up));
            chk("cyc_pulse_down", int'(PulseDown), int'(ep_pulse && !m_up));
        end
    end

    // Issue one request and wait for Ready; optionally inject a second
    // request inj_at cycles in, which the DUT must ignore.
    task automatic seek(input int t, input int inj_at, input int inj_t, input int e_up,
                        input int e_dn, input int e_lat, input int e_pos, input string nm);
        int lat, ups, dns;
        bit got;
        lat = 0; ups = 0; dns = 0; got = 1'b0; npos = 0;
        @(negedge Clk);
        Request = 1'b1;
        Target = 4'(t);
        while (!got && lat < 60) begin
            @(negedge Clk);
            lat++;
            if (lat == inj_at) begin
                Request = 1'b1;
                Target = 4'(inj_t);
            end else begin
                Request = 1'b0;
            end
            if (PulseUp || PulseDown) begin
                if (npos < 10) pos_log[npos] = Position;
                npos++;
            end
            ups += int'(PulseUp);
            dns += int'(PulseDown);
            if (Ready) got = 1'b1;
        end
        Request = 1'b0;
        chk({nm, "_ready_seen"}, int'(got), 1);
        chk({nm, "_latency"}, lat, e_lat);
        chk({nm, "_up_pulses"}, ups, e_up);
        chk({nm, "_down_pulses"}, dns, e_dn);
        chk({nm, "_final_pos"}, int'(Position), e_pos);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (2) @(negedge Clk);
        chk("reset_position", int'(Position), 'h001);
        chk("reset_digit", int'(Digit), 0);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_ready", int'(Ready), 0);
        Rst_n = 1'b1;
        cmp_en = 1'b1;

        seek(3, 0, 0, 3, 0, 13, 'h008, "s0to3");
        chk("s0to3_step1", int'(pos_log[0]), 'h002);
        chk("s0to3_step2", int'(pos_log[1]), 'h004);
        chk("s0to3_step3", int'(pos_log[2]), 'h008);
        chk("s0to3_digit", int'(Digit), 3);

        seek(8, 0, 0, 5, 0, 21, 'h100, "s3to8_tie");

        seek(1, 0, 0, 3, 0, 13, 'h002, "s8to1_wrap");
        chk("s8to1_step1", int'(pos_log[0]), 'h200);
        chk("s8to1_step2", int'(pos_log[1]), 'h001);
        chk("s8to1_step3", int'(pos_log[2]), 'h002);

        seek(7, 0, 0, 0, 4, 17, 'h080, "s1to7_down");
        chk("s1to7_step1", int'(pos_log[0]), 'h001);
        chk("s1to7_step2", int'(pos_log[1]), 'h200);
        chk("s1to7_step3", int'(pos_log[2]), 'h100);
        chk("s1to7_step4", int'(pos_log[3]), 'h080);

        seek(7, 0, 0, 0, 0, 1, 'h080, "s7to7_zero");

        @(negedge Clk);
        Request = 1'b1;
        Target = 4'hC;
        @(negedge Clk);
        Request = 1'b0;
        chk("bad_target_error", int'(Error), 1);
        chk("bad_target_busy", int'(Busy), 0);
        chk("bad_target_pos", int'(Position), 'h080);
        @(negedge Clk);
        chk("bad_target_error_clear", int'(Error), 0);

        seek(2, 3, 9, 5, 0, 21, 'h004, "s7to2_ignore_mid");

        @(negedge Clk);
        Request = 1'b1;
        Target = 4'd6;
        @(negedge Clk);
        Request = 1'b0;
        repeat (4) @(negedge Clk);
        chk("rst_mid_pre_pos", int'(Position), 'h008);
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("rst_mid_pos", int'(Position), 'h001);
        chk("rst_mid_busy", int'(Busy), 0);
        chk("rst_mid_pulse_up", int'(PulseUp), 0);
        chk("rst_mid_pulse_down", int'(PulseDown), 0);
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;

        seek(4, 0, 0, 4, 0, 17, 'h010, "s0to4_after_rst");

        @(negedge Clk);
        Request1 = 1'b1;
        Target1 = 4'd5;
        for (int k = 0; k <= 6; k++) begin
            @(negedge Clk);
            Request1 = 1'b0;
            chk("sd1_pulse_up", int'(PulseUp1), int'(k >= 1 && k <= 5));
            chk("sd1_pulse_down", int'(PulseDown1), 0);
            chk("sd1_ready", int'(Ready1), int'(k == 5));
            chk("sd1_busy", int'(Busy1), int'(k <= 4));
            chk("sd1_position", int'(Position1), 1 << ((k < 5) ? k : 5));
        end
        chk("sd1_digit", int'(Digit1), 5);
        chk("sd1_error", int'(Error1), 0);

        repeat (2) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
